// File: rtl/csr_arb_mux_if.sv
// Bundled CSR master-side and slave-side channels for the N-to-1 CSR arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding environment's view.
interface csr_arb_mux_if #(
  parameter int unsigned NUM_M  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PRIV_W = 2
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [NUM_M-1:0]        m_req_valid;
  logic [NUM_M-1:0]        m_req_write;
  logic [NUM_M*ADDR_W-1:0] m_req_addr;
  logic [NUM_M*DATA_W-1:0] m_req_wdata;
  logic [NUM_M*STRB_W-1:0] m_req_wstrb;
  logic [NUM_M*PRIV_W-1:0] m_req_priv;
  logic [NUM_M-1:0]        m_req_ready;
  logic [NUM_M-1:0]        m_rsp_valid;
  logic [NUM_M-1:0]        m_rsp_ready;
  logic [NUM_M*DATA_W-1:0] m_rsp_rdata;
  logic [NUM_M-1:0]        m_rsp_fault;
  logic [NUM_M-1:0]        m_rsp_side_effect;

  logic                    s_req_valid;
  logic                    s_req_write;
  logic [ADDR_W-1:0]       s_req_addr;
  logic [DATA_W-1:0]       s_req_wdata;
  logic [STRB_W-1:0]       s_req_wstrb;
  logic [PRIV_W-1:0]       s_req_priv;
  logic                    s_req_ready;
  logic                    s_rsp_valid;
  logic [DATA_W-1:0]       s_rsp_rdata;
  logic                    s_rsp_fault;
  logic                    s_rsp_side_effect;
  logic                    s_rsp_ready;

  modport slave (
    input  m_req_valid, m_req_write, m_req_addr, m_req_wdata, m_req_wstrb, m_req_priv,
    output m_req_ready,
    output m_rsp_valid, m_rsp_rdata, m_rsp_fault, m_rsp_side_effect,
    input  m_rsp_ready,
    output s_req_valid, s_req_write, s_req_addr, s_req_wdata, s_req_wstrb, s_req_priv,
    input  s_req_ready,
    input  s_rsp_valid, s_rsp_rdata, s_rsp_fault, s_rsp_side_effect,
    output s_rsp_ready
  );

  modport master (
    output m_req_valid, m_req_write, m_req_addr, m_req_wdata, m_req_wstrb, m_req_priv,
    input  m_req_ready,
    input  m_rsp_valid, m_rsp_rdata, m_rsp_fault, m_rsp_side_effect,
    output m_rsp_ready,
    input  s_req_valid, s_req_write, s_req_addr, s_req_wdata, s_req_wstrb, s_req_priv,
    output s_req_ready,
    output s_rsp_valid, s_rsp_rdata, s_rsp_fault, s_rsp_side_effect,
    input  s_rsp_ready
  );
endinterface

// File: rtl/csr_arb_mux.sv
// Round-robin N-to-1 CSR arbiter: one registered request slot toward the slave and
// an ID FIFO that routes in-order responses back to the granted master.
module csr_arb_mux #(
  parameter  int unsigned NUM_M   = 4,
  parameter  int unsigned ADDR_W  = 32,
  parameter  int unsigned DATA_W  = 32,
  parameter  int unsigned PRIV_W  = 2,
  parameter  int unsigned MAX_OUT = 4,
  localparam int unsigned CNT_W   = $clog2(MAX_OUT + 1),
  localparam int unsigned IDX_W   = $clog2(NUM_M)
) (
  input  logic             clk,
  input  logic             rst_n,
  csr_arb_mux_if.slave     bus,
  output logic [CNT_W-1:0] outstanding,
  output logic             err_unexp_rsp,
  input  logic             err_clr
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned PTR_W  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v);
    return IDX_W'(v % NUM_M);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic              s_req_valid_q, s_req_valid_d;
  logic              s_req_write_q, s_req_write_d;
  logic [ADDR_W-1:0] s_req_addr_q,  s_req_addr_d;
  logic [DATA_W-1:0] s_req_wdata_q, s_req_wdata_d;
  logic [STRB_W-1:0] s_req_wstrb_q, s_req_wstrb_d;
  logic [PRIV_W-1:0] s_req_priv_q,  s_req_priv_d;
  logic [IDX_W-1:0]  rr_q,          rr_d;
  logic [PTR_W-1:0]  wr_ptr_q,      wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,      rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q,         cnt_d;
  logic              err_q,         err_d;
  logic [IDX_W-1:0]  id_mem_q [MAX_OUT];

  logic              any_valid;
  logic [IDX_W-1:0]  win_idx;
  logic              slot_free;
  logic              grant;
  logic [IDX_W-1:0]  head;
  logic              fifo_nonempty;
  logic              rsp_ready;
  logic              pop;
  logic              unexp;

  // First valid master at or after the round-robin pointer.
  always_comb begin
    any_valid = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 0; k < NUM_M; k++) begin
      if (!any_valid && bus.m_req_valid[wrap_idx(32'(rr_q) + k)]) begin
        any_valid = 1'b1;
        win_idx   = wrap_idx(32'(rr_q) + k);
      end
    end
  end

  // Grant uses only registered count, never the response path.
  always_comb begin
    slot_free     = !s_req_valid_q || bus.s_req_ready;
    grant         = rst_n && slot_free && (cnt_q < CNT_W'(MAX_OUT)) && any_valid;
    head          = id_mem_q[rd_ptr_q];
    fifo_nonempty = (cnt_q != '0);
    rsp_ready     = 1'b0;
    if (rst_n) begin
      rsp_ready = fifo_nonempty ? bus.m_rsp_ready[head] : 1'b1;
    end
    pop   = rst_n && fifo_nonempty && bus.s_rsp_valid && rsp_ready;
    unexp = rst_n && !fifo_nonempty && bus.s_rsp_valid;
  end

  always_comb begin
    s_req_valid_d = s_req_valid_q;
    s_req_write_d = s_req_write_q;
    s_req_addr_d  = s_req_addr_q;
    s_req_wdata_d = s_req_wdata_q;
    s_req_wstrb_d = s_req_wstrb_q;
    s_req_priv_d  = s_req_priv_q;
    rr_d          = rr_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    cnt_d         = cnt_q;
    err_d         = err_q;

    if (grant) begin
      s_req_valid_d = 1'b1;
      s_req_write_d = bus.m_req_write[win_idx];
      s_req_addr_d  = bus.m_req_addr[32'(win_idx) * ADDR_W +: ADDR_W];
      s_req_wdata_d = bus.m_req_wdata[32'(win_idx) * DATA_W +: DATA_W];
      s_req_wstrb_d = bus.m_req_wstrb[32'(win_idx) * STRB_W +: STRB_W];
      s_req_priv_d  = bus.m_req_priv[32'(win_idx) * PRIV_W +: PRIV_W];
      rr_d          = wrap_idx(32'(win_idx) + 32'd1);
      wr_ptr_d      = ptr_inc(wr_ptr_q);
    end else if (bus.s_req_ready) begin
      s_req_valid_d = 1'b0;
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({grant, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    // A new unexpected response outranks a clear in the same cycle.
    if (unexp) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_req_valid_q <= 1'b0;
      s_req_write_q <= 1'b0;
      s_req_addr_q  <= '0;
      s_req_wdata_q <= '0;
      s_req_wstrb_q <= '0;
      s_req_priv_q  <= '0;
      rr_q          <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      for (int unsigned i = 0; i < MAX_OUT; i++) begin
        id_mem_q[i] <= '0;
      end
    end else begin
      s_req_valid_q <= s_req_valid_d;
      s_req_write_q <= s_req_write_d;
      s_req_addr_q  <= s_req_addr_d;
      s_req_wdata_q <= s_req_wdata_d;
      s_req_wstrb_q <= s_req_wstrb_d;
      s_req_priv_q  <= s_req_priv_d;
      rr_q          <= rr_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      if (grant) begin
        id_mem_q[wr_ptr_q] <= win_idx;
      end
    end
  end

  assign bus.m_req_ready       = grant ? (NUM_M'(1) << win_idx) : '0;
  assign bus.m_rsp_valid       = (rst_n && fifo_nonempty && bus.s_rsp_valid) ? (NUM_M'(1) << head) : '0;
  assign bus.m_rsp_rdata       = {NUM_M{bus.s_rsp_rdata}};
  assign bus.m_rsp_fault       = {NUM_M{bus.s_rsp_fault}};
  assign bus.m_rsp_side_effect = {NUM_M{bus.s_rsp_side_effect}};
  assign bus.s_rsp_ready       = rsp_ready;

  assign bus.s_req_valid = s_req_valid_q;
  assign bus.s_req_write = s_req_write_q;
  assign bus.s_req_addr  = s_req_addr_q;
  assign bus.s_req_wdata = s_req_wdata_q;
  assign bus.s_req_wstrb = s_req_wstrb_q;
  assign bus.s_req_priv  = s_req_priv_q;

  assign outstanding   = cnt_q;
  assign err_unexp_rsp = err_q;
endmodule

// File: tb/tb_csr_arb_mux.sv
// Bench for csr_arb_mux: queue-based reference model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_csr_arb_mux;
  localparam int unsigned NM = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned PW = 2;
  localparam int unsigned MO = 4;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = $clog2(MO + 1);

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          err_clr = 1'b0;
  logic [CW-1:0] outstanding;
  logic          err_unexp_rsp;

  csr_arb_mux_if #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW), .PRIV_W(PW)) bus ();

  csr_arb_mux #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW), .PRIV_W(PW), .MAX_OUT(MO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .outstanding(outstanding),
    .err_unexp_rsp(err_unexp_rsp), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: arbitration pointer, queue of granted master IDs, slot copy, error flag.
  int            mdl_rr  = 0;
  int            mdl_ids[$];
  logic          mdl_sv  = 1'b0;
  logic          mdl_sw  = 1'b0;
  logic [AW-1:0] mdl_sa  = '0;
  logic [DW-1:0] mdl_sd  = '0;
  logic [SW-1:0] mdl_ss  = '0;
  logic [PW-1:0] mdl_sp  = '0;
  logic          mdl_err = 1'b0;

  logic          e_grant, e_pop, e_unexp, e_srr;
  int            e_win;
  logic [NM-1:0] e_mrr, e_mrv;

  task automatic model_eval();
    int m;
    e_grant = 1'b0; e_win = 0; e_mrr = '0; e_mrv = '0;
    e_srr = 1'b0; e_pop = 1'b0; e_unexp = 1'b0;
    if (rst_n) begin
      if ((!mdl_sv || bus.s_req_ready) && mdl_ids.size() < int'(MO)) begin
        for (int k = 0; k < int'(NM); k++) begin
          m = (mdl_rr + k) % int'(NM);
          if (!e_grant && bus.m_req_valid[m]) begin
            e_grant = 1'b1;
            e_win   = m;
          end
        end
      end
      if (e_grant) e_mrr[e_win] = 1'b1;
      if (mdl_ids.size() > 0) begin
        e_srr = bus.m_rsp_ready[mdl_ids[0]];
        if (bus.s_rsp_valid) e_mrv[mdl_ids[0]] = 1'b1;
        e_pop = bus.s_rsp_valid && e_srr;
      end else begin
        e_srr   = 1'b1;
        e_unexp = bus.s_rsp_valid;
      end
    end
  endtask

  always @(negedge clk) begin
    model_eval();
    chk("m_req_ready", 128'(bus.m_req_ready), 128'(e_mrr));
    chk("m_rsp_valid", 128'(bus.m_rsp_valid), 128'(e_mrv));
    chk("s_rsp_ready", 128'(bus.s_rsp_ready), 128'(e_srr));
    chk("s_req_valid", 128'(bus.s_req_valid), 128'(mdl_sv));
    chk("s_req_write", 128'(bus.s_req_write), 128'(mdl_sw));
    chk("s_req_addr",  128'(bus.s_req_addr),  128'(mdl_sa));
    chk("s_req_wdata", 128'(bus.s_req_wdata), 128'(mdl_sd));
    chk("s_req_wstrb", 128'(bus.s_req_wstrb), 128'(mdl_ss));
    chk("s_req_priv",  128'(bus.s_req_priv),  128'(mdl_sp));
    chk("outstanding", 128'(outstanding),     128'(mdl_ids.size()));
    chk("err_unexp",   128'(err_unexp_rsp),   128'(mdl_err));
    chk("m_rsp_rdata", 128'(bus.m_rsp_rdata), 128'({NM{bus.s_rsp_rdata}}));
    chk("m_rsp_flags", 128'({bus.m_rsp_fault, bus.m_rsp_side_effect}),
        128'({{NM{bus.s_rsp_fault}}, {NM{bus.s_rsp_side_effect}}}));
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_rr = 0; mdl_ids.delete(); mdl_sv = 1'b0; mdl_sw = 1'b0;
      mdl_sa = '0; mdl_sd = '0; mdl_ss = '0; mdl_sp = '0; mdl_err = 1'b0;
    end else begin
      if (e_pop) void'(mdl_ids.pop_front());
      if (e_grant) begin
        mdl_ids.push_back(e_win);
        mdl_sv = 1'b1;
        mdl_sw = bus.m_req_write[e_win];
        mdl_sa = bus.m_req_addr[e_win*AW +: AW];
        mdl_sd = bus.m_req_wdata[e_win*DW +: DW];
        mdl_ss = bus.m_req_wstrb[e_win*SW +: SW];
        mdl_sp = bus.m_req_priv[e_win*PW +: PW];
        mdl_rr = (e_win + 1) % int'(NM);
      end else if (bus.s_req_ready) begin
        mdl_sv = 1'b0;
      end
      if (e_unexp) mdl_err = 1'b1;
      else if (err_clr) mdl_err = 1'b0;
    end
  end

  function automatic int oh2i(input logic [NM-1:0] v);
    for (int i = 0; i < int'(NM); i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic zero_inputs();
    bus.m_req_valid = '0; bus.m_req_write = '0; bus.m_req_addr = '0;
    bus.m_req_wdata = '0; bus.m_req_wstrb = '0; bus.m_req_priv = '0;
    bus.m_rsp_ready = '1; bus.s_req_ready = 1'b1; bus.s_rsp_valid = 1'b0;
    bus.s_rsp_rdata = '0; bus.s_rsp_fault = 1'b0; bus.s_rsp_side_effect = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic do_reset();
    nxt();
    rst_n = 1'b0;
    zero_inputs();
    nxt();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    int gq[$];
    int rq[$];
    int exp_ord[6] = '{0, 1, 2, 3, 0, 1};
    int pend;
    int ng;
    logic hs, acc;

    zero_inputs();
    bus.m_req_valid = 4'hF;
    bus.s_rsp_valid = 1'b1;
    #3;
    chk("rst_m_req_ready", 128'(bus.m_req_ready), 128'(0));
    chk("rst_s_rsp_ready", 128'(bus.s_rsp_ready), 128'(0));
    chk("rst_m_rsp_valid", 128'(bus.m_rsp_valid), 128'(0));
    chk("rst_s_req_valid", 128'(bus.s_req_valid), 128'(0));
    chk("rst_outstanding", 128'(outstanding), 128'(0));
    nxt();
    rst_n = 1'b1;
    zero_inputs();
    nxt();

    // Single write from master 2, answered in the cycle the slave accepts it.
    bus.m_req_valid = 4'b0100;
    bus.m_req_write = 4'b0100;
    bus.m_req_addr[2*AW +: AW]  = 32'h10;
    bus.m_req_wdata[2*DW +: DW] = 32'hA5A5_0001;
    bus.m_req_wstrb[2*SW +: SW] = 4'hF;
    bus.m_req_priv[2*PW +: PW]  = 2'd3;
    mid();
    chk("single_grant", 128'(bus.m_req_ready), 128'(4'b0100));
    nxt();
    bus.m_req_valid = '0;
    bus.s_rsp_valid = 1'b1;
    bus.s_rsp_rdata = 32'h1234;
    mid();
    chk("single_s_req_valid", 128'(bus.s_req_valid), 128'(1));
    chk("single_s_req_addr", 128'(bus.s_req_addr), 128'(32'h10));
    chk("single_s_req_wdata", 128'(bus.s_req_wdata), 128'(32'hA5A5_0001));
    chk("single_outstanding", 128'(outstanding), 128'(1));
    chk("single_rsp_route", 128'(bus.m_rsp_valid), 128'(4'b0100));
    chk("single_rsp_rdata", 128'(bus.m_rsp_rdata[2*DW +: DW]), 128'(32'h1234));
    nxt();
    bus.s_rsp_valid = 1'b0;
    mid();
    chk("single_outstanding_after", 128'(outstanding), 128'(0));
    chk("single_slot_drained", 128'(bus.s_req_valid), 128'(0));

    // Round-robin with all masters requesting; slave answers one cycle after accepting.
    do_reset();
    bus.m_req_valid = 4'hF;
    pend = 0;
    for (int c = 0; c < 40; c++) begin
      mid();
      if (bus.m_req_ready != '0) gq.push_back(oh2i(bus.m_req_ready));
      if (bus.m_rsp_valid != '0 && bus.s_rsp_ready) rq.push_back(oh2i(bus.m_rsp_valid));
      hs  = bus.s_rsp_valid && bus.s_rsp_ready;
      acc = bus.s_req_valid && bus.s_req_ready;
      nxt();
      if (hs) pend--;
      if (acc) pend++;
      bus.s_rsp_valid = (pend > 0);
      bus.s_rsp_rdata = 32'(c + 32'h100);
      if (gq.size() >= 6) bus.m_req_valid = '0;
      if (gq.size() >= 6 && rq.size() >= 6 && pend == 0) break;
    end
    bus.s_rsp_valid = 1'b0;
    chk("rr_grant_count", 128'(gq.size()), 128'(6));
    chk("rr_rsp_count", 128'(rq.size()), 128'(6));
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr_grant_%0d", i), 128'((i < gq.size()) ? gq[i] : -1), 128'(exp_ord[i]));
      chk($sformatf("rr_rsp_%0d", i), 128'((i < rq.size()) ? rq[i] : -1), 128'(exp_ord[i]));
    end

    // Saturation: slave accepts but never answers.
    do_reset();
    bus.m_req_valid = 4'hF;
    ng = 0;
    for (int c = 0; c < 8; c++) begin
      mid();
      if (bus.m_req_ready != '0) ng++;
      nxt();
    end
    mid();
    chk("sat_grants", 128'(ng), 128'(4));
    chk("sat_outstanding", 128'(outstanding), 128'(4));
    chk("sat_no_grant", 128'(bus.m_req_ready), 128'(0));
    nxt();
    bus.s_rsp_valid = 1'b1;
    mid();
    chk("sat_full_no_grant_on_pop", 128'(bus.m_req_ready), 128'(0));
    chk("sat_rsp_to_m0", 128'(bus.m_rsp_valid), 128'(4'b0001));
    nxt();
    bus.s_rsp_valid = 1'b0;
    mid();
    chk("sat_outstanding_3", 128'(outstanding), 128'(3));
    chk("sat_resume_grant", 128'(bus.m_req_ready), 128'(4'b0001));
    nxt();
    bus.m_req_valid = '0;
    mid();
    chk("sat_refilled", 128'(outstanding), 128'(4));

    // Backpressure: slot stays put while the slave stalls.
    do_reset();
    bus.s_req_ready = 1'b0;
    bus.m_req_valid = 4'b0010;
    bus.m_req_addr[1*AW +: AW] = 32'h40;
    mid();
    chk("bp_first_grant", 128'(bus.m_req_ready), 128'(4'b0010));
    nxt();
    bus.m_req_addr[1*AW +: AW] = 32'h44;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk($sformatf("bp_hold_addr_%0d", i), 128'(bus.s_req_addr), 128'(32'h40));
      chk($sformatf("bp_no_grant_%0d", i), 128'(bus.m_req_ready), 128'(0));
      nxt();
    end
    bus.s_req_ready = 1'b1;
    mid();
    chk("bp_resume_grant", 128'(bus.m_req_ready), 128'(4'b0010));
    nxt();
    bus.m_req_valid = '0;
    mid();
    chk("bp_new_addr", 128'(bus.s_req_addr), 128'(32'h44));
    chk("bp_outstanding", 128'(outstanding), 128'(2));

    // Unexpected response with nothing outstanding.
    do_reset();
    bus.m_rsp_ready = '0;
    bus.s_rsp_valid = 1'b1;
    mid();
    chk("unexp_s_rsp_ready", 128'(bus.s_rsp_ready), 128'(1));
    chk("unexp_m_rsp_valid", 128'(bus.m_rsp_valid), 128'(0));
    nxt();
    bus.s_rsp_valid = 1'b0;
    mid();
    chk("unexp_err_set", 128'(err_unexp_rsp), 128'(1));
    nxt();
    err_clr = 1'b1;
    mid();
    chk("unexp_err_hold", 128'(err_unexp_rsp), 128'(1));
    nxt();
    err_clr = 1'b0;
    mid();
    chk("unexp_err_clr", 128'(err_unexp_rsp), 128'(0));
    nxt();
    err_clr = 1'b1;
    bus.s_rsp_valid = 1'b1;
    nxt();
    err_clr = 1'b0;
    bus.s_rsp_valid = 1'b0;
    mid();
    chk("unexp_set_beats_clr", 128'(err_unexp_rsp), 128'(1));
    bus.m_rsp_ready = '1;

    // Asynchronous reset with three requests in flight, then a late response.
    do_reset();
    bus.m_req_valid = 4'hF;
    nxt();
    nxt();
    nxt();
    bus.m_req_valid = '0;
    mid();
    chk("mid_rst_outstanding_3", 128'(outstanding), 128'(3));
    #1;
    rst_n = 1'b0;
    bus.m_req_valid = 4'hF;
    bus.s_rsp_valid = 1'b1;
    #1;
    chk("mid_rst_m_req_ready", 128'(bus.m_req_ready), 128'(0));
    chk("mid_rst_s_req_valid", 128'(bus.s_req_valid), 128'(0));
    chk("mid_rst_outstanding", 128'(outstanding), 128'(0));
    chk("mid_rst_s_rsp_ready", 128'(bus.s_rsp_ready), 128'(0));
    nxt();
    rst_n = 1'b1;
    mid();
    chk("post_rst_grant_m0", 128'(bus.m_req_ready), 128'(4'b0001));
    chk("post_rst_late_rsp_drop", 128'(bus.m_rsp_valid), 128'(0));
    chk("post_rst_late_rsp_ready", 128'(bus.s_rsp_ready), 128'(1));
    nxt();
    bus.s_rsp_valid = 1'b0;
    bus.m_req_valid = '0;
    mid();
    chk("post_rst_err", 128'(err_unexp_rsp), 128'(1));
    chk("post_rst_outstanding", 128'(outstanding), 128'(1));
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
